multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-003 SHALL have ports opcode and func, input, 6 bits each: instruction[31:26] and [5:0], held stable by the IR.
REQ-004 SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completes the access in this cycle.
REQ-006 SHALL have outputs mem_req, memread, memwrite, iord, irwrite, pc_en, regwrite, regdst, mem2reg, alusrca, extop, instr_done, illegal, each 1 bit.
REQ-007 SHALL have outputs alusrcb (2 bits: 00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2), pcsource (2 bits: 00 ALU result, 01 ALUOut, 10 jump addr), aluop (4 bits), state (4 bits, debug).

Function
REQ-008 SHALL implement a Moore FSM (outputs from state; pc_en and the handshake gating also depend on Zero and mem_ready) with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, IEXEC, IWB, BRANCH, JUMP.
REQ-009 SHALL use the following ALU and mux settings per state:
- FETCH: mem_req=memread=1, iord=0, alusrca=0, alusrcb=01, aluop=ADD, pcsource=00.
- DECODE: alusrca=0, alusrcb=11, extop=1, aluop=ADD.
REQ-010 FETCH SHALL hold until mem_ready=1, asserting irwrite and pc_en only in the mem_ready cycle, then go to DECODE.
REQ-011 DECODE SHALL dispatch on opcode:
- 100011 (lw) and 101011 (sw) -> MEMADR.
- 000000 -> RTEXEC.
- 001000, 001100, 001101 (addi/andi/ori) -> IEXEC.
- 000100 (beq) -> BRANCH.
- 000010 (j) -> JUMP.
- Any other opcode -> FETCH with illegal=1 for one cycle.
REQ-012 MEMADR SHALL drive alusrca=1, alusrcb=10, extop=1, aluop=ADD, then go to MEMRD (lw) or MEMWR (sw).
REQ-013 MEMRD and MEMWR SHALL drive mem_req=1 and iord=1, with memread=1 (MEMRD) or memwrite=1 (MEMWR), and hold until mem_ready; MEMRD then goes to MEMWB, MEMWR then goes to FETCH.
REQ-014 MEMWB SHALL drive regwrite=1, regdst=0, mem2reg=1, then go to FETCH.
REQ-015 RTEXEC SHALL drive alusrca=1, alusrcb=00, with aluop from func: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; an unknown func SHALL go to FETCH with illegal=1 and no write.
REQ-016 RTWB SHALL drive regwrite=1, regdst=1, mem2reg=0.
REQ-017 IEXEC SHALL drive alusrca=1, alusrcb=10, with aluop ADD/AND/OR for addi/andi/ori; extop=1 only for addi.
REQ-018 IWB SHALL drive regwrite=1, regdst=0, mem2reg=0.
REQ-019 BRANCH SHALL drive alusrca=1, alusrcb=00, aluop=SUB, pcsource=01, pc_en=Zero.
REQ-020 JUMP SHALL drive pcsource=10, pc_en=1.
REQ-021 instr_done SHALL pulse for one cycle in the last state of each legal instruction: MEMWB, MEMWR (ready cycle), RTWB, IWB, BRANCH, JUMP.
REQ-022 With zero-wait memory (mem_ready tied 1), latency SHALL be: lw 5, sw 4, R-type 4, I-type ALU 4, beq 3, j 3 cycles.
REQ-023 Each wait cycle (mem_ready=0) SHALL add exactly one cycle; while waiting, pc_en, irwrite and regwrite SHALL be 0.
REQ-024 regwrite, memwrite and pc_en SHALL never be asserted outside the states listed above.

Reset
REQ-025 While rst_n=0 at a clock edge, the FSM SHALL go to FETCH.
REQ-026 While rst_n=0, all outputs SHALL be 0, including mem_req, and state=FETCH encoding 0.
REQ-027 Reset asserted mid-instruction, including during a memory wait, SHALL abandon the instruction with no write strobe in the reset cycles.

Structure
REQ-028 The state enumeration, opcode/func constants, aluop codes (ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0100), and alusrcb/pcsource encodings SHALL live in shared package mc_pkg.
REQ-029 Decoding of func/opcode to aluop SHALL be a sub-module alu_decoder; the rest of the block is a single FSM.

Verification
REQ-030 lw (0x8C0A0004) with mem_ready=1: states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1, mem2reg=1 in cycle 5; instr_done in cycle 5.
REQ-031 sw with mem_ready low 3 cycles in MEMWR: memwrite held 4 cycles, instr_done only in the ready cycle, no regwrite.
REQ-032 beq with Zero=1 gives pc_en=1, pcsource=01 in cycle 3; repeated with Zero=0, pc_en stays 0.
REQ-033 opcode 111111: illegal pulses in DECODE, next state FETCH, no write strobes; R-type func 000000: same.
REQ-034 rst_n=0 during a MEMRD wait: next cycle is state FETCH with all outputs 0; after release, FETCH asserts mem_req.
REQ-035 R-type sub (func 100010): aluop=0001 in RTEXEC, regdst=1 and regwrite=1 in RTWB, 4 cycles total.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle processor control block.
//   - state_t   : FSM state encoding (FETCH is 0 so the reset state reads as 0)
//   - OP_*/FN_* : opcode and R-type func field values
//   - ALU_*     : aluop codes driven to the ALU
//   - SRCB_*    : alusrcb mux selects (reg B, const 4, ext imm, ext imm<<2)
//   - PCSRC_*   : pcsource mux selects (ALU result, ALUOut, jump address)
//   - ctrl_t    : bundle of every datapath control output
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEXEC = 4'd6,
        RTWB   = 4'd7,
        IEXEC  = 4'd8,
        IWB    = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pc_en;
        logic       regwrite;
        logic       regdst;
        logic       mem2reg;
        logic       alusrca;
        logic       extop;
        logic       instr_done;
        logic       illegal;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic [3:0] aluop;
    } ctrl_t;

    function automatic logic is_itype_alu(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder for the multicycle control block.
// Ports:
//   opcode, func  : instruction fields [31:26] and [5:0]
//   rtype_aluop   : ALU op selected by func for R-type instructions
//   rtype_valid   : func is one of the supported R-type operations
//   itype_aluop   : ALU op for the immediate ALU instructions
//   itype_extop   : sign-extend the immediate (addi only; andi/ori zero-extend)
module alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output logic [3:0] rtype_aluop,
    output logic       rtype_valid,
    output logic [3:0] itype_aluop,
    output logic       itype_extop
);

    always_comb begin
        rtype_aluop = ALU_ADD;
        rtype_valid = 1'b1;
        case (func)
            FN_ADD:  rtype_aluop = ALU_ADD;
            FN_SUB:  rtype_aluop = ALU_SUB;
            FN_AND:  rtype_aluop = ALU_AND;
            FN_OR:   rtype_aluop = ALU_OR;
            FN_SLT:  rtype_aluop = ALU_SLT;
            default: rtype_valid = 1'b0;
        endcase
    end

    always_comb begin
        itype_aluop = ALU_ADD;
        itype_extop = 1'b0;
        case (opcode)
            OP_ADDI: begin
                itype_aluop = ALU_ADD;
                itype_extop = 1'b1;
            end
            OP_ANDI: itype_aluop = ALU_AND;
            OP_ORI:  itype_aluop = ALU_OR;
            default: itype_aluop = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control unit: a single Moore FSM that sequences
// fetch, decode, execute, memory and write-back for lw/sw, R-type ALU,
// addi/andi/ori, beq and j.
// Ports:
//   clk, rst_n     : clock and synchronous active-low reset
//   opcode, func   : instruction fields from the IR
//   Zero           : ALU zero flag (beq decision)
//   mem_ready      : memory completes the access this cycle
//   mem_req, memread, memwrite, iord, irwrite, pc_en, regwrite, regdst,
//   mem2reg, alusrca, extop, alusrcb, pcsource, aluop : datapath controls
//   instr_done     : last cycle of a legal instruction
//   illegal        : one-cycle pulse on an unsupported opcode/func
//   state          : current state (debug)
module multicycle_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pc_en,
    output logic       regwrite,
    output logic       regdst,
    output logic       mem2reg,
    output logic       alusrca,
    output logic       extop,
    output logic       instr_done,
    output logic       illegal,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic [3:0] aluop,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    logic [3:0] rtype_aluop;
    logic       rtype_valid;
    logic [3:0] itype_aluop;
    logic       itype_extop;

    alu_decoder u_alu_decoder (
        .opcode      (opcode),
        .func        (func),
        .rtype_aluop (rtype_aluop),
        .rtype_valid (rtype_valid),
        .itype_aluop (itype_aluop),
        .itype_extop (itype_extop)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            FETCH: begin
                ctrl.mem_req  = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.alusrcb  = SRCB_FOUR;
                ctrl.pcsource = PCSRC_ALU;
                ctrl.aluop    = ALU_ADD;
                if (mem_ready) begin
                    ctrl.irwrite = 1'b1;
                    ctrl.pc_en   = 1'b1;
                    state_d      = DECODE;
                end
            end
            DECODE: begin
                // Branch target is computed here speculatively (PC + imm<<2).
                ctrl.alusrcb = SRCB_IMM_SH2;
                ctrl.extop   = 1'b1;
                ctrl.aluop   = ALU_ADD;
                // func is already stable in the IR, so a bad R-type func is
                // rejected here rather than spending a cycle in RTEXEC.
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = MEMADR;
                end else if (opcode == OP_RTYPE && rtype_valid) begin
                    state_d = RTEXEC;
                end else if (is_itype_alu(opcode)) begin
                    state_d = IEXEC;
                end else if (opcode == OP_BEQ) begin
                    state_d = BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = JUMP;
                end else begin
                    ctrl.illegal = 1'b1;
                    state_d      = FETCH;
                end
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.extop   = 1'b1;
                ctrl.aluop   = ALU_ADD;
                state_d      = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                ctrl.memread = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
                if (mem_ready) begin
                    ctrl.instr_done = 1'b1;
                    state_d         = FETCH;
                end
            end
            MEMWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.mem2reg    = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = FETCH;
            end
            RTEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REG;
                ctrl.aluop   = rtype_aluop;
                if (rtype_valid) begin
                    state_d = RTWB;
                end else begin
                    ctrl.illegal = 1'b1;
                    state_d      = FETCH;
                end
            end
            RTWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.regdst     = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = FETCH;
            end
            IEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = itype_aluop;
                ctrl.extop   = itype_extop;
                state_d      = IWB;
            end
            IWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = FETCH;
            end
            BRANCH: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SRCB_REG;
                ctrl.aluop      = ALU_SUB;
                ctrl.pcsource   = PCSRC_ALUOUT;
                ctrl.pc_en      = Zero;
                ctrl.instr_done = 1'b1;
                state_d         = FETCH;
            end
            JUMP: begin
                ctrl.pcsource   = PCSRC_JUMP;
                ctrl.pc_en      = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Reset is synchronous, so the state register may still hold a mid-
    // instruction state during the first reset cycle; gating the outputs
    // with rst_n guarantees no strobe or request escapes while in reset.
    assign ctrl_out = rst_n ? ctrl : '0;
    assign state    = rst_n ? state_q : FETCH;

    assign mem_req    = ctrl_out.mem_req;
    assign memread    = ctrl_out.memread;
    assign memwrite   = ctrl_out.memwrite;
    assign iord       = ctrl_out.iord;
    assign irwrite    = ctrl_out.irwrite;
    assign pc_en      = ctrl_out.pc_en;
    assign regwrite   = ctrl_out.regwrite;
    assign regdst     = ctrl_out.regdst;
    assign mem2reg    = ctrl_out.mem2reg;
    assign alusrca    = ctrl_out.alusrca;
    assign extop      = ctrl_out.extop;
    assign instr_done = ctrl_out.instr_done;
    assign illegal    = ctrl_out.illegal;
    assign alusrcb    = ctrl_out.alusrcb;
    assign pcsource   = ctrl_out.pcsource;
    assign aluop      = ctrl_out.aluop;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is expanded
// into its expected per-cycle output vectors, pushed to a scoreboard queue
// together with the mem_ready value for that cycle, then replayed cycle by
// cycle against the DUT.
module tb_multicycle_control;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3;
    localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTEXEC = 4'd6, S_RTWB = 4'd7;
    localparam logic [3:0] S_IEXEC = 4'd8, S_IWB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] func = 6'd0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, memread, memwrite, iord, irwrite, pc_en, regwrite;
    logic       regdst, mem2reg, alusrca, extop, instr_done, illegal;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] aluop, state;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .memread(memread),
        .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pc_en(pc_en),
        .regwrite(regwrite), .regdst(regdst), .mem2reg(mem2reg),
        .alusrca(alusrca), .extop(extop), .instr_done(instr_done),
        .illegal(illegal), .alusrcb(alusrcb), .pcsource(pcsource),
        .aluop(aluop), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic mem_req, memread, memwrite, iord, irwrite, pc_en, regwrite;
        logic regdst, mem2reg, alusrca, extop, instr_done, illegal;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [3:0] aluop;
    } vec_t;

    vec_t  exp_q[$];
    logic  rdy_q[$];
    string tag_q[$];
    int    checks = 0;
    int    failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic vec_t blank(input logic [3:0] st);
        vec_t v;
        v = '0;
        v.st = st;
        return v;
    endfunction

    function automatic vec_t observed();
        vec_t v;
        v.st = state; v.mem_req = mem_req; v.memread = memread; v.memwrite = memwrite;
        v.iord = iord; v.irwrite = irwrite; v.pc_en = pc_en; v.regwrite = regwrite;
        v.regdst = regdst; v.mem2reg = mem2reg; v.alusrca = alusrca; v.extop = extop;
        v.instr_done = instr_done; v.illegal = illegal; v.srcb = alusrcb;
        v.pcsrc = pcsource; v.aluop = aluop;
        return v;
    endfunction

    task automatic push(input vec_t v, input logic rdy, input string tag);
        exp_q.push_back(v);
        rdy_q.push_back(rdy);
        tag_q.push_back(tag);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected sequence for one instruction; fw = fetch wait cycles,
    // mw = data memory wait cycles. Zero must already hold the beq outcome.
    task automatic push_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                              input int fw, input int mw);
        vec_t v;
        logic [3:0] r_op;
        logic r_ok;
        logic legal;
        r_ok = 1'b1;
        r_op = 4'd0;
        case (fn)
            6'b100000: r_op = 4'b0000;
            6'b100010: r_op = 4'b0001;
            6'b100100: r_op = 4'b0010;
            6'b100101: r_op = 4'b0011;
            6'b101010: r_op = 4'b0100;
            default:   r_ok = 1'b0;
        endcase
        legal = (op inside {6'b100011, 6'b101011, 6'b001000, 6'b001100, 6'b001101,
                            6'b000100, 6'b000010}) || (op == 6'b000000 && r_ok);
        for (int i = 0; i <= fw; i++) begin
            v = blank(S_FETCH); v.mem_req = 1; v.memread = 1; v.srcb = 2'b01;
            if (i == fw) begin v.irwrite = 1; v.pc_en = 1; end
            push(v, (i == fw), $sformatf("%s.fetch%0d", name, i));
        end
        v = blank(S_DECODE); v.srcb = 2'b11; v.extop = 1;
        if (!legal) begin
            v.illegal = 1;
            push(v, rnd_bit(), {name, ".decode_illegal"});
            return;
        end
        push(v, rnd_bit(), {name, ".decode"});
        case (op)
            6'b100011, 6'b101011: begin
                v = blank(S_MEMADR); v.alusrca = 1; v.srcb = 2'b10; v.extop = 1;
                push(v, rnd_bit(), {name, ".memadr"});
                for (int i = 0; i <= mw; i++) begin
                    v = blank(op == 6'b100011 ? S_MEMRD : S_MEMWR);
                    v.mem_req = 1; v.iord = 1;
                    if (op == 6'b100011) v.memread = 1;
                    else begin
                        v.memwrite = 1;
                        v.instr_done = (i == mw);
                    end
                    push(v, (i == mw), $sformatf("%s.mem%0d", name, i));
                end
                if (op == 6'b100011) begin
                    v = blank(S_MEMWB); v.regwrite = 1; v.mem2reg = 1; v.instr_done = 1;
                    push(v, rnd_bit(), {name, ".memwb"});
                end
            end
            6'b000000: begin
                v = blank(S_RTEXEC); v.alusrca = 1; v.aluop = r_op;
                push(v, rnd_bit(), {name, ".rtexec"});
                v = blank(S_RTWB); v.regwrite = 1; v.regdst = 1; v.instr_done = 1;
                push(v, rnd_bit(), {name, ".rtwb"});
            end
            6'b001000, 6'b001100, 6'b001101: begin
                v = blank(S_IEXEC); v.alusrca = 1; v.srcb = 2'b10;
                v.aluop = (op == 6'b001000) ? 4'b0000 : (op == 6'b001100) ? 4'b0010 : 4'b0011;
                v.extop = (op == 6'b001000);
                push(v, rnd_bit(), {name, ".iexec"});
                v = blank(S_IWB); v.regwrite = 1; v.instr_done = 1;
                push(v, rnd_bit(), {name, ".iwb"});
            end
            6'b000100: begin
                v = blank(S_BRANCH); v.alusrca = 1; v.aluop = 4'b0001; v.pcsrc = 2'b01;
                v.pc_en = Zero; v.instr_done = 1;
                push(v, rnd_bit(), {name, ".branch"});
            end
            default: begin
                v = blank(S_JUMP); v.pcsrc = 2'b10; v.pc_en = 1; v.instr_done = 1;
                push(v, rnd_bit(), {name, ".jump"});
            end
        endcase
    endtask

    // Replays up to n scoreboard entries (n < 0: all). Entered and left at
    // posedge+1; outputs are sampled on the falling edge.
    task automatic run_n(input int n);
        vec_t  e;
        string t;
        while (exp_q.size() > 0 && n != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            mem_ready = rdy_q.pop_front();
            @(negedge clk);
            check_eq(t, 32'(observed()), 32'(e));
            @(posedge clk);
            #1;
            n--;
        end
    endtask

    task automatic do_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int fw, input int mw);
        opcode = op;
        func   = fn;
        Zero   = z;
        push_instr(name, op, fn, fw, mw);
        run_n(-1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) push(blank(S_FETCH), rnd_bit(), "reset");
        run_n(-1);
        rst_n = 1'b1;

        // lw 0x8C0A0004
        do_instr("lw",      6'b100011, 6'b000100, 1'b0, 0, 0);
        do_instr("sw_wait", 6'b101011, 6'b000000, 1'b0, 0, 3);
        do_instr("sub",     6'b000000, 6'b100010, 1'b0, 0, 0);
        do_instr("add",     6'b000000, 6'b100000, 1'b1, 0, 0);
        do_instr("and",     6'b000000, 6'b100100, 1'b0, 1, 0);
        do_instr("or",      6'b000000, 6'b100101, 1'b0, 0, 0);
        do_instr("slt",     6'b000000, 6'b101010, 1'b0, 2, 0);
        do_instr("addi",    6'b001000, 6'b000000, 1'b0, 0, 0);
        do_instr("andi",    6'b001100, 6'b111111, 1'b0, 0, 0);
        do_instr("ori",     6'b001101, 6'b000000, 1'b0, 0, 0);
        do_instr("beq_z1",  6'b000100, 6'b000000, 1'b1, 0, 0);
        do_instr("beq_z0",  6'b000100, 6'b000000, 1'b0, 0, 0);
        do_instr("j",       6'b000010, 6'b000000, 1'b1, 0, 0);
        do_instr("bad_op",  6'b111111, 6'b100000, 1'b0, 0, 0);
        do_instr("bad_fn",  6'b000000, 6'b000000, 1'b0, 0, 0);
        do_instr("lw_wait", 6'b100011, 6'b000000, 1'b0, 1, 2);

        // Reset asserted in the middle of a MEMRD wait.
        opcode = 6'b100011;
        func   = 6'b000000;
        push_instr("lw_rst", 6'b100011, 6'b000000, 0, 3);
        run_n(4);
        exp_q.delete();
        rdy_q.delete();
        tag_q.delete();
        rst_n = 1'b0;
        push(blank(S_FETCH), 1'b0, "rst_in_wait");
        push(blank(S_FETCH), 1'b1, "rst_after");
        run_n(-1);
        rst_n = 1'b1;
        do_instr("j_post_rst", 6'b000010, 6'b000000, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
